card_deal_packer: RTL
=====================

Name: card_deal_packer

Overview:
- Upstream stage of the WinRate engine. Collects one dealt card per cycle over a valid/ready handshake.
- Rejects illegal deals: out-of-range rank or a duplicate card.
- Packs 18 hole cards (9 players × 2) and 3 public cards into the WinRate input buses. Issues them as a one-cycle in_valid pulse.
- Holds off new cards until WinRate returns out_valid.

Parameters:
NUM_PLAYERS, 9, players per deal; sets hole bus widths (8·N rank bits, 4·N suit bits)
NUM_PUB, 3, public cards per deal; sets public bus widths (4·P rank bits, 2·P suit bits)

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
card_valid  in  1  card_num/card_suit valid this cycle
card_num  in  4  rank; legal range 1..13
card_suit  in  2  suit 0..3
card_ready  out  1  block accepts a card this cycle
wr_out_valid  in  1  out_valid from WinRate; ends the wait
pk_valid  out  1  drives WinRate in_valid; one-cycle pulse
pk_hole_num  out  72  hole ranks; player p card c at bits [4(2p+c)+3 : 4(2p+c)]
pk_hole_suit  out  36  hole suits; player p card c at bits [2(2p+c)+1 : 2(2p+c)]
pk_pub_num  out  12  public ranks; card k at bits [4k+3 : 4k]
pk_pub_suit  out  6  public suits; card k at bits [2k+1 : 2k]
err_valid  out  1  one-cycle pulse when a deal is aborted
err_code  out  2  1 = rank out of range, 2 = duplicate card; 0 when err_valid is low

Behaviour:
- Reset (async, any state): state=COLLECT, cnt=0, 52-bit used-mask cleared, all data registers cleared. Outputs: card_ready=1, pk_valid=0, err_valid=0, err_code=0, all pk buses 0.
- Accept condition: card_valid && card_ready. Card order:
  - cnt 0..17 are hole cards: player = cnt/2, card = cnt%2.
  - cnt 18..20 are public cards 0..2.
- Card id = suit·13 + (num−1), range 0..51.
- COLLECT, card_ready=1. On accept:
  - num==0 or num>13: abort with err_code=1. Range check has priority over the duplicate check.
  - used[id] already set: abort with err_code=2.
  - Otherwise: store the card, set used[id], cnt++.
  - The 21st legal card (cnt==20) moves the state to ISSUE.
  - Abort means: err_valid=1 with err_code for exactly the next cycle, cnt=0, mask cleared, stay in COLLECT. card_ready stays 1, so the card arriving in the following cycle is the first card of a new deal.
- ISSUE: one cycle, card_ready=0, pk_valid=1, pk buses carry the packed deal, then WAIT.
  - Latency: last card accepted at edge T, pk_valid high in cycle T+1.
- WAIT: card_ready=0; card_valid is ignored. On wr_out_valid=1: cnt=0, mask cleared, state=COLLECT, card_ready=1 from the next cycle.
- wr_out_valid is ignored in COLLECT and ISSUE.
- pk buses are 0 whenever pk_valid=0.
- Outputs are registered or decoded from registered state only. No combinational path from card_* to any output.
- card_valid may have gaps; cnt holds across idle cycles. No timeout.
- Reset mid-deal or mid-WAIT discards everything. No pk_valid or err_valid follows the reset.

Decomposition:
- Package card_deal_pkg:
  - constants NUM_CARDS=21, RANK_MIN=1, RANK_MAX=13, DECK=52
  - err codes ERR_NONE=0, ERR_RANGE=1, ERR_DUP=2
  - state enum {COLLECT, ISSUE, WAIT}
  - typedef card_t {num[3:0], suit[1:0]}
- One sub-module, card_mask_tracker:
  - Computes id, range_err and dup_err from (num, suit, used-mask).
  - Owns the 52-bit mask with set and clear inputs.
- The packer holds the FSM, cnt and the bus registers.

Test Plan:
1. Reset: assert rst_n=0 mid-clock, asynchronously → card_ready=1, pk_valid=0, err_valid=0, all pk buses 0 immediately.
2. Legal deal:
   - Stimulus: card i (i=0..20) = num (i%13)+1, suit i/13, back-to-back.
   - Response: pk_valid exactly one cycle after the 21st accept; pk_hole_num[3:0]=1, pk_hole_num[71:68]=5, pk_pub_num=0x876 (cards 18,19,20 = 6,7,8); card_ready=0 from that cycle.
3. Duplicate: 5th card repeats card 2 (num 3, suit 0) → err_valid=1 and err_code=2 for one cycle, no pk_valid. A subsequent full legal deal packs correctly from index 0.
4. Range: card with num=14 at cnt=10 → err_code=1. Same with num=0. The num=0 case also matches an already-used id and must still report err_code=1, proving range has priority.
5. Backpressure: after ISSUE, drive card_valid=1 for 30 cycles → no accepts and no state change. Pulse wr_out_valid → card_ready=1 next cycle. The next deal may reuse the previous deal's cards with no duplicate error.
6. Gaps and reset: deal with random idle cycles → same packed result. Repeat, asserting rst_n at cnt=12 → no pk_valid; the next deal starts at player 0.

Source files
------------

// File: rtl/card_deal_pkg.sv
// Shared constants, types and the card-id helper for the card deal packer.
package card_deal_pkg;

    localparam int unsigned NUM_CARDS = 21;
    localparam logic [3:0]  RANK_MIN  = 4'd1;
    localparam logic [3:0]  RANK_MAX  = 4'd13;
    localparam int unsigned DECK      = 52;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_DUP   = 2'd2;

    typedef enum logic [1:0] {COLLECT, ISSUE, WAIT} state_e;

    typedef struct packed {
        logic [3:0] num;
        logic [1:0] suit;
    } card_t;

    // Only meaningful for in-range ranks; num==0 wraps and is filtered by the range check.
    function automatic logic [5:0] card_id(card_t c);
        return 6'(c.suit) * 6'd13 + 6'(c.num) - 6'd1;
    endfunction

endpackage

// File: rtl/card_deal_packer_if.sv
// Card input handshake plus the packed deal and error outputs toward WinRate.
interface card_deal_packer_if #(
    parameter int unsigned NUM_PLAYERS = 9,
    parameter int unsigned NUM_PUB     = 3
);
    logic                     card_valid;
    logic [3:0]               card_num;
    logic [1:0]               card_suit;
    logic                     card_ready;
    logic                     wr_out_valid;
    logic                     pk_valid;
    logic [8*NUM_PLAYERS-1:0] pk_hole_num;
    logic [4*NUM_PLAYERS-1:0] pk_hole_suit;
    logic [4*NUM_PUB-1:0]     pk_pub_num;
    logic [2*NUM_PUB-1:0]     pk_pub_suit;
    logic                     err_valid;
    logic [1:0]               err_code;

    modport master (
        output card_valid, card_num, card_suit, wr_out_valid,
        input  card_ready, pk_valid, pk_hole_num, pk_hole_suit, pk_pub_num, pk_pub_suit,
        input  err_valid, err_code
    );

    modport slave (
        input  card_valid, card_num, card_suit, wr_out_valid,
        output card_ready, pk_valid, pk_hole_num, pk_hole_suit, pk_pub_num, pk_pub_suit,
        output err_valid, err_code
    );
endinterface

// File: rtl/card_mask_tracker.sv
// Tracks which of the 52 cards have been dealt and classifies the incoming card.
module card_mask_tracker
    import card_deal_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  card_t card,
    input  logic  set,
    input  logic  clr,
    output logic  range_err,
    output logic  dup_err
);

    logic [DECK-1:0] used_q, used_d;
    logic [63:0]     used_ext;
    logic [5:0]      id;

    always_comb begin
        id        = card_id(card);
        range_err = (card.num < RANK_MIN) || (card.num > RANK_MAX);
        used_ext  = {{(64 - DECK){1'b0}}, used_q};
        dup_err   = (id < 6'(DECK)) && used_ext[id];
        used_d    = used_q;
        if (clr) begin
            used_d = '0;
        end else if (set) begin
            used_d = used_q | DECK'(64'd1 << id);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_q <= '0;
        end else begin
            used_q <= used_d;
        end
    end

endmodule

// File: rtl/card_deal_packer.sv
// Collects a full deal card by card, rejects illegal cards and issues the packed deal to WinRate.
module card_deal_packer
    import card_deal_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS = 9,
    parameter int unsigned NUM_PUB     = 3
) (
    input logic              clk,
    input logic              rst_n,
    card_deal_packer_if.slave bus
);

    localparam int unsigned NumHole = 2 * NUM_PLAYERS;
    localparam int unsigned Total   = NumHole + NUM_PUB;
    localparam int unsigned CntW    = $clog2(Total + 1);

    state_e                   state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [4*NumHole-1:0]     hole_num_q, hole_num_d;
    logic [2*NumHole-1:0]     hole_suit_q, hole_suit_d;
    logic [4*NUM_PUB-1:0]     pub_num_q, pub_num_d;
    logic [2*NUM_PUB-1:0]     pub_suit_q, pub_suit_d;
    logic                     err_valid_q, err_valid_d;
    logic [1:0]               err_code_q, err_code_d;

    card_t card_in;
    logic  accept, range_err, dup_err, mask_set, mask_clr;
    int    pub_idx;

    assign card_in = {bus.card_num, bus.card_suit};
    assign accept  = bus.card_valid && (state_q == COLLECT);

    card_mask_tracker u_mask (
        .clk       (clk),
        .rst_n     (rst_n),
        .card      (card_in),
        .set       (mask_set),
        .clr       (mask_clr),
        .range_err (range_err),
        .dup_err   (dup_err)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hole_num_d  = hole_num_q;
        hole_suit_d = hole_suit_q;
        pub_num_d   = pub_num_q;
        pub_suit_d  = pub_suit_q;
        err_valid_d = 1'b0;
        err_code_d  = ERR_NONE;
        mask_set    = 1'b0;
        mask_clr    = 1'b0;
        pub_idx     = int'(cnt_q) - int'(NumHole);
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (range_err || dup_err) begin
                        // Range outranks duplicate: a num of 0 can alias a used id.
                        err_valid_d = 1'b1;
                        err_code_d  = range_err ? ERR_RANGE : ERR_DUP;
                        cnt_d       = '0;
                        mask_clr    = 1'b1;
                    end else begin
                        mask_set = 1'b1;
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q < CntW'(NumHole)) begin
                            hole_num_d[4*int'(cnt_q) +: 4]  = card_in.num;
                            hole_suit_d[2*int'(cnt_q) +: 2] = card_in.suit;
                        end else begin
                            pub_num_d[4*pub_idx +: 4]  = card_in.num;
                            pub_suit_d[2*pub_idx +: 2] = card_in.suit;
                        end
                        if (cnt_q == CntW'(Total - 1)) begin
                            state_d = ISSUE;
                        end
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.wr_out_valid) begin
                    cnt_d    = '0;
                    mask_clr = 1'b1;
                    state_d  = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            hole_num_q  <= '0;
            hole_suit_q <= '0;
            pub_num_q   <= '0;
            pub_suit_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hole_num_q  <= hole_num_d;
            hole_suit_q <= hole_suit_d;
            pub_num_q   <= pub_num_d;
            pub_suit_q  <= pub_suit_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.card_ready   = (state_q == COLLECT);
    assign bus.pk_valid     = (state_q == ISSUE);
    assign bus.pk_hole_num  = bus.pk_valid ? hole_num_q  : '0;
    assign bus.pk_hole_suit = bus.pk_valid ? hole_suit_q : '0;
    assign bus.pk_pub_num   = bus.pk_valid ? pub_num_q   : '0;
    assign bus.pk_pub_suit  = bus.pk_valid ? pub_suit_q  : '0;
    assign bus.err_valid    = err_valid_q;
    assign bus.err_code     = err_code_q;

endmodule
